frog_mover: RTL

Parametrised frog position controller for the Frogger playfield. Turns the four debounced direction buttons into a registered (col, row) grid position. Moves one cell per press, auto-repeats while a button is held, and clamps or wraps at the playfield edges. Supports a respawn command from game logic. Sits between the input synchroniser/debouncer and the display/collision logic.

---
 rtl/frog_pkg.sv | 31 +++
 rtl/frog_repeat_timer.sv | 37 +++
 rtl/frog_mover.sv | 132 +++++++++++++
 3 files changed

// File: rtl/frog_pkg.sv
// Shared types and the edge-aware position step used by the frog position controller.
package frog_pkg;

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT,
      LOCKOUT
   } mover_state_t;

   // Off-grid steps either wrap to the opposite edge or leave the position where it was.
   function automatic int next_pos(input int pos, input int delta, input int size, input bit wrap);
      int sum;
      sum = pos + delta;
      if (sum < 0)
         next_pos = wrap ? size - 1 : pos;
      else if (sum >= size)
         next_pos = wrap ? 0 : pos;
      else
         next_pos = sum;
   endfunction

endpackage

// File: rtl/frog_repeat_timer.sv
// Auto-repeat down-counter: a new press loads the initial delay, each fire reloads the repeat rate.
module frog_repeat_timer #(
   parameter int REPEAT_DELAY = 4,
   parameter int REPEAT_RATE  = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic restart_i,
   input  logic active_i,
   output logic fire_o
);

   localparam int MAX_LOAD = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W    = (MAX_LOAD < 2) ? 1 : $clog2(MAX_LOAD);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign fire_o = active_i && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (restart_i)
         cnt_d = CNT_W'(REPEAT_DELAY - 1);
      else if (fire_o)
         cnt_d = CNT_W'(REPEAT_RATE - 1);
      else if (active_i)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/frog_mover.sv
// Frog grid position controller: prioritised direction decode, press/auto-repeat FSM,
// edge clamp or wrap, respawn with lockout until the buttons are released.
module frog_mover
   import frog_pkg::*;
#(
   parameter int COLS         = 16,
   parameter int ROWS         = 16,
   parameter int START_COL    = COLS / 2,
   parameter int START_ROW    = ROWS - 1,
   parameter int REPEAT_DELAY = 4,
   parameter int REPEAT_RATE  = 2,
   parameter int WRAP         = 0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      l,
   input  logic                      r,
   input  logic                      u,
   input  logic                      d,
   input  logic                      en,
   input  logic                      respawn,
   output logic [$clog2(COLS)-1:0]   col,
   output logic [$clog2(ROWS)-1:0]   row,
   output logic                      moved,
   output logic                      at_goal
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   dir_t          dir;
   dir_t          dir_q, dir_d;
   mover_state_t  state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          moved_q, moved_d;
   logic          at_goal_q;
   logic          new_press, active, fire, move_req;
   int            col_delta, row_delta, col_tgt, row_tgt;

   always_comb begin
      dir = DIR_NONE;
      if (u)
         dir = DIR_UP;
      else if (d)
         dir = DIR_DOWN;
      else if (l)
         dir = DIR_LEFT;
      else if (r)
         dir = DIR_RIGHT;
   end

   // Same button still held while delaying/repeating: let the timer run.
   assign active = !respawn && en && (state_q inside {DELAY, REPEAT})
                   && (dir != DIR_NONE) && (dir == dir_q);

   frog_repeat_timer #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
   ) u_timer (
      .clock     (clock),
      .reset     (reset),
      .restart_i (new_press),
      .active_i  (active),
      .fire_o    (fire)
   );

   always_comb begin
      col_delta = (dir == DIR_LEFT) ? -1 : (dir == DIR_RIGHT) ? 1 : 0;
      row_delta = (dir == DIR_UP)   ? -1 : (dir == DIR_DOWN)  ? 1 : 0;
      col_tgt   = next_pos(int'(col_q), col_delta, COLS, WRAP != 0);
      row_tgt   = next_pos(int'(row_q), row_delta, ROWS, WRAP != 0);
   end

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      col_d     = col_q;
      row_d     = row_q;
      moved_d   = 1'b0;
      new_press = 1'b0;
      move_req  = 1'b0;
      if (respawn) begin
         state_d = LOCKOUT;
         col_d   = CW'(START_COL);
         row_d   = RW'(START_ROW);
      end else if (state_q == LOCKOUT) begin
         if (dir == DIR_NONE)
            state_d = IDLE;
      end else if (!en || dir == DIR_NONE) begin
         state_d = IDLE;
      end else if (state_q == IDLE || dir != dir_q) begin
         new_press = 1'b1;
         move_req  = 1'b1;
         state_d   = DELAY;
         dir_d     = dir;
      end else if (fire) begin
         move_req = 1'b1;
         state_d  = REPEAT;
      end
      // A clamped move keeps the position, so moved only reflects a real change.
      if (move_req) begin
         col_d   = CW'(col_tgt);
         row_d   = RW'(row_tgt);
         moved_d = (col_d != col_q) || (row_d != row_q);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         dir_q     <= DIR_NONE;
         col_q     <= CW'(START_COL);
         row_q     <= RW'(START_ROW);
         moved_q   <= 1'b0;
         at_goal_q <= (START_ROW == 0);
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         col_q     <= col_d;
         row_q     <= row_d;
         moved_q   <= moved_d;
         at_goal_q <= (row_d == '0);
      end
   end

   assign col     = col_q;
   assign row     = row_q;
   assign moved   = moved_q;
   assign at_goal = at_goal_q;

endmodule
